// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers upstream samples in a small FIFO and emits one
// sample every RATE_DIV clocks to the FIR sink. An empty FIFO at emission time
// produces a flagged zero sample so the filter cadence never breaks.
module fir_sample_feeder #(
  parameter int DATA_W   = 24,
  parameter int DEPTH    = 16,
  parameter int RATE_DIV = 1250
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [DATA_W-1:0]        ast_sink_data,
  output logic                     ast_sink_valid,
  output logic [1:0]               ast_sink_error,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RATE_DIV);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(RATE_DIV - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [CW-1:0]     cnt;
  logic              refused;
  logic              push, pop, tick, empty, refuse;

  // Ready looks only at registered occupancy; a same-cycle pop does not
  // open a slot for a push.
  assign wr_ready   = !reset && (count != FULL);
  assign empty      = (count == '0);
  assign push       = wr_valid && wr_ready;
  assign refuse     = wr_valid && !wr_ready && !reset;
  assign tick       = run && (cnt == CNT_MAX);
  assign pop        = tick && !empty;
  assign fill_level = count;

  // Pacing counter: held at 0 while stopped so a restart gives a full period.
  always_ff @(posedge clk) begin
    if (reset || !run || tick) cnt <= '0;
    else                       cnt <= cnt + CW'(1);
  end

  // Sample storage; writes are blocked during reset through wr_ready.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally; occupancy tracks push/pop, unchanged on both.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky refused-push flag; a refusal in the tick cycle itself is kept
  // for the following emission.
  always_ff @(posedge clk) begin
    if (reset)       refused <= 1'b0;
    else if (tick)   refused <= refuse;
    else if (refuse) refused <= 1'b1;
  end

  // Emission register: strobe in the cycle after the tick, data/error hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      ast_sink_valid <= 1'b0;
      ast_sink_data  <= '0;
      ast_sink_error <= 2'b00;
    end else begin
      ast_sink_valid <= tick;
      if (tick) begin
        ast_sink_data  <= pop ? mem[rd_ptr] : '0;
        ast_sink_error <= {refused, empty};
      end
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed and randomised checks of fir_sample_feeder with RATE_DIV=4, DEPTH=4.
module tb_fir_sample_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [23:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [23:0] ast_sink_data;
  logic        ast_sink_valid;
  logic [1:0]  ast_sink_error;
  logic [2:0]  fill_level;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  localparam logic [23:0] T1_D [4] = '{24'd100, 24'd200, 24'hFFFED4, 24'd0};
  localparam logic [1:0]  T1_E [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
  localparam logic [23:0] T2_D [4] = '{24'd2, 24'd3, 24'd4, 24'd0};
  localparam logic [1:0]  T2_E [4] = '{2'b00, 2'b00, 2'b00, 2'b01};

  fir_sample_feeder #(.DATA_W(24), .DEPTH(4), .RATE_DIV(4)) dut (
    .clk(clk), .reset(reset), .run(run),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .ast_sink_data(ast_sink_data), .ast_sink_valid(ast_sink_valid),
    .ast_sink_error(ast_sink_error), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // Reset for two edges with run set to r; returns in cycle 0 with reset low.
  task automatic do_reset(input logic r);
    reset = 1'b1; wr_valid = 1'b0; run = r;
    cyc(); cyc();
    check("rst_ready", 32'(wr_ready), 0);
    check("rst_valid", 32'(ast_sink_valid), 0);
    check("rst_fill", 32'(fill_level), 0);
    check("rst_data", 32'(ast_sink_data), 0);
    check("rst_err", 32'(ast_sink_error), 0);
    reset = 1'b0;
    #1;
    cyc_n = 0;
  endtask

  task automatic next_strobe(output int dt);
    dt = 0;
    do begin
      cyc();
      dt++;
    end while (!ast_sink_valid && dt < 64);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dt;
    int last;
    int mcnt;
    logic mref;
    logic exp_v;
    logic [23:0] exp_d;
    logic [1:0]  exp_e;
    logic ready_m;
    logic [23:0] q[$];

    // Basic emission order and underflow.
    do_reset(1'b1);
    check("t1_ready0", 32'(wr_ready), 1);
    wr_valid = 1'b1; wr_data = 24'd100;     cyc();
    wr_data = 24'd200;                      cyc();
    wr_data = 24'hFFFED4;                   cyc();
    wr_valid = 1'b0;
    check("t1_fill", 32'(fill_level), 3);
    while (cyc_n <= 16) begin
      check("t1_valid", 32'(ast_sink_valid), 32'((cyc_n % 4 == 0) && cyc_n >= 4));
      if (cyc_n % 4 == 0 && cyc_n >= 4) begin
        check("t1_data", 32'(ast_sink_data), 32'(T1_D[cyc_n/4-1]));
        check("t1_err", 32'(ast_sink_error), 32'(T1_E[cyc_n/4-1]));
      end
      cyc();
    end

    // Overflow: full FIFO refuses a fifth sample, flagged on next emission.
    do_reset(1'b0);
    for (int i = 1; i <= 4; i++) begin
      wr_valid = 1'b1; wr_data = 24'(i); cyc();
    end
    check("t2_fill4", 32'(fill_level), 4);
    check("t2_ready0", 32'(wr_ready), 0);
    wr_data = 24'd5; cyc();
    check("t2_fill4b", 32'(fill_level), 4);
    check("t2_ready0b", 32'(wr_ready), 0);
    wr_valid = 1'b0; run = 1'b1;
    next_strobe(dt);
    check("t2_dt", 32'(dt), 4);
    check("t2_data", 32'(ast_sink_data), 1);
    check("t2_err", 32'(ast_sink_error), 2);
    check("t2_fill3", 32'(fill_level), 3);
    check("t2_ready1", 32'(wr_ready), 1);
    for (int k = 0; k < 4; k++) begin
      next_strobe(dt);
      check("t2_dtn", 32'(dt), 4);
      check("t2_datan", 32'(ast_sink_data), 32'(T2_D[k]));
      check("t2_errn", 32'(ast_sink_error), 32'(T2_E[k]));
    end

    // Push exactly in the tick cycle of an empty FIFO: no bypass.
    cyc(); cyc(); cyc();
    wr_valid = 1'b1; wr_data = 24'd7; cyc();
    wr_valid = 1'b0;
    check("t3_valid", 32'(ast_sink_valid), 1);
    check("t3_data", 32'(ast_sink_data), 0);
    check("t3_err", 32'(ast_sink_error), 1);
    check("t3_fill", 32'(fill_level), 1);
    next_strobe(dt);
    check("t3_dt", 32'(dt), 4);
    check("t3_data7", 32'(ast_sink_data), 7);
    check("t3_err7", 32'(ast_sink_error), 0);

    // Stopped pacing holds the buffer; restart gives a full period.
    wr_valid = 1'b1; wr_data = 24'd11; cyc();
    wr_data = 24'd12; cyc();
    wr_valid = 1'b0; run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("t4_valid", 32'(ast_sink_valid), 0);
      check("t4_fill", 32'(fill_level), 2);
      cyc();
    end
    run = 1'b1;
    next_strobe(dt);
    check("t4_dt", 32'(dt), 4);
    check("t4_data", 32'(ast_sink_data), 11);
    check("t4_err", 32'(ast_sink_error), 0);

    // One-cycle reset mid-stream with 3 buffered and cnt=2.
    run = 1'b0;
    wr_valid = 1'b1; wr_data = 24'd21; cyc();
    wr_data = 24'd22; cyc();
    wr_valid = 1'b0; run = 1'b1; cyc();
    cyc();
    check("t5_fill3", 32'(fill_level), 3);
    reset = 1'b1;
    #1;
    check("t5_ready_rst", 32'(wr_ready), 0);
    cyc();
    reset = 1'b0;
    #1;
    check("t5_fill", 32'(fill_level), 0);
    check("t5_valid", 32'(ast_sink_valid), 0);
    check("t5_data", 32'(ast_sink_data), 0);
    check("t5_err", 32'(ast_sink_error), 0);
    check("t5_ready", 32'(wr_ready), 1);
    next_strobe(dt);
    check("t5_dt", 32'(dt), 4);
    check("t5_udata", 32'(ast_sink_data), 0);
    check("t5_uerr", 32'(ast_sink_error), 1);

    // Random bursty pushes against a queue-based reference.
    do_reset(1'b1);
    mcnt = 0; mref = 1'b0; exp_v = 1'b0; exp_d = '0; exp_e = '0; last = -1;
    q.delete();
    for (int i = 0; i < 10000; i++) begin
      check("r_valid", 32'(ast_sink_valid), 32'(exp_v));
      if (ast_sink_valid) begin
        check("r_data", 32'(ast_sink_data), 32'(exp_d));
        check("r_err", 32'(ast_sink_error), 32'(exp_e));
        if (last >= 0) check("r_period", 32'(cyc_n - last), 4);
        last = cyc_n;
      end
      wr_valid = ((i % 64) < 16) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) < 3);
      wr_data  = 24'($urandom());
      ready_m  = (q.size() != 4);
      #1;
      check("r_ready", 32'(wr_ready), 32'(ready_m));
      exp_v = (mcnt == 3);
      if (mcnt == 3) begin
        if (q.size() > 0) begin
          exp_d = q.pop_front();
          exp_e = {mref, 1'b0};
        end else begin
          exp_d = '0;
          exp_e = {mref, 1'b1};
        end
        mref = wr_valid && !ready_m;
      end else if (wr_valid && !ready_m) begin
        mref = 1'b1;
      end
      if (wr_valid && ready_m) q.push_back(wr_data);
      mcnt = (mcnt + 1) % 4;
      cyc();
    end
    wr_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
